// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the RAM port between the CPU bus (priority) and one external requester
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
    input  logic                  cpu_mem_read,
    input  logic                  cpu_mem_write,
    input  logic [DATA_WIDTH-1:0] cpu_mem_data_out,
    output logic [DATA_WIDTH-1:0] cpu_mem_data_in,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_busy,
    output logic                  ext_ack,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_timeout,
    output logic                  grant_ext,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
    state_t                state;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         wait_cnt;
    logic                  bus_free;
    assign bus_free        = !cpu_mem_read && !cpu_mem_write;
    assign grant_ext       = (state == PEND) && bus_free;
    assign cpu_mem_data_in = ram_rdata;
    // RAM port follows the CPU except in the single cycle the external access is granted
    always_comb begin
        ram_address = grant_ext ? addr_q  : cpu_mem_address;
        ram_read    = grant_ext ? !we_q   : cpu_mem_read;
        ram_write   = grant_ext ? we_q    : cpu_mem_write;
        ram_wdata   = grant_ext ? wdata_q : cpu_mem_data_out;
    end
    // request FSM: latch in IDLE, wait for a free bus in PEND, pulse ack in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            ext_busy    <= 1'b0;
            ext_ack     <= 1'b0;
            ext_timeout <= 1'b0;
            ext_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ext_ack <= 1'b0;
                    if (ext_req) begin
                        we_q        <= ext_we;
                        addr_q      <= ext_addr;
                        wdata_q     <= ext_wdata;
                        wait_cnt    <= '0;
                        ext_timeout <= 1'b0;
                        ext_busy    <= 1'b1;
                        state       <= PEND;
                    end
                end
                PEND: begin
                    if (bus_free) begin
                        if (!we_q) ext_rdata <= ram_rdata;
                        ext_ack <= 1'b1;
                        state   <= DONE;
                    end else if (wait_cnt != CW'(WAIT_LIMIT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CW'(WAIT_LIMIT - 1)) ext_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    ext_ack  <= 1'b0;
                    ext_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table-driven checks of the CPU/external RAM arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_mem_address;
    logic        cpu_mem_read, cpu_mem_write;
    logic [7:0]  cpu_mem_data_out, cpu_mem_data_in;
    logic        ext_req, ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata;
    logic        ext_busy, ext_ack, ext_timeout, grant_ext;
    logic [15:0] ram_address;
    logic        ram_read, ram_write;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  mem [0:65535];
    int total = 0;
    int bad = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_address(cpu_mem_address), .cpu_mem_read(cpu_mem_read),
        .cpu_mem_write(cpu_mem_write), .cpu_mem_data_out(cpu_mem_data_out),
        .cpu_mem_data_in(cpu_mem_data_in),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_busy(ext_busy), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .ext_timeout(ext_timeout), .grant_ext(grant_ext),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // behavioural RAM: combinational read, write on the clock edge
    assign ram_rdata = mem[ram_address];
    always @(posedge clk) if (ram_write) mem[ram_address] <= ram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_mem_read = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_mem_address = 16'h0000;
        cpu_mem_data_out = 8'h00;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
        int          blk;
        logic [7:0]  exp_rd;
    } xfer_t;

    typedef struct {
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic [7:0]  d;
        logic        chk_din;
        logic [7:0]  din;
    } mux_t;

    xfer_t xt [7];
    mux_t  mt [6];
    logic  prev_to = 1'b0;

    task automatic xfer(input xfer_t x);
        @(negedge clk);
        cpu_idle();
        ext_req = 1'b1; ext_we = x.we; ext_addr = x.a; ext_wdata = x.d;
        #1;
        chk("idle_busy", ext_busy, 0);
        chk("idle_grant", grant_ext, 0);
        chk("idle_timeout", ext_timeout, prev_to);
        for (int i = 0; i < x.blk; i++) begin
            @(negedge clk);
            ext_req = 1'b0;
            cpu_mem_read = 1'b1;
            cpu_mem_address = 16'h0200 + 16'(i);
            #1;
            chk("blk_grant", grant_ext, 0);
            chk("blk_addr", ram_address, 16'h0200 + 16'(i));
            chk("blk_rw", {ram_read, ram_write}, 2'b10);
            chk("blk_busy_ack", {ext_busy, ext_ack}, 2'b10);
            chk("blk_timeout", ext_timeout, i >= 4);
        end
        @(negedge clk);
        ext_req = 1'b0;
        cpu_idle();
        #1;
        chk("acc_grant", grant_ext, 1);
        chk("acc_addr", ram_address, x.a);
        chk("acc_rw", {ram_read, ram_write}, {!x.we, x.we});
        if (x.we) chk("acc_wdata", ram_wdata, x.d);
        else chk("acc_din", cpu_mem_data_in, x.exp_rd);
        chk("acc_busy_ack", {ext_busy, ext_ack}, 2'b10);
        chk("acc_timeout", ext_timeout, x.blk >= 4);
        @(negedge clk);
        #1;
        chk("ack_pulse", {ext_busy, ext_ack, grant_ext}, 3'b110);
        chk("ack_rdata", ext_rdata, x.exp_rd);
        chk("ack_timeout", ext_timeout, x.blk >= 4);
        @(negedge clk);
        #1;
        chk("post_idle", {ext_busy, ext_ack, grant_ext}, 3'b000);
        prev_to = x.blk >= 4;
    endtask

    initial begin
        int g;
        int k;
        xt[0] = '{1'b1, 16'h1234, 8'hA5, 0,  8'h00};
        xt[1] = '{1'b1, 16'h0040, 8'h3C, 0,  8'h00};
        xt[2] = '{1'b0, 16'h0040, 8'h00, 0,  8'h3C};
        xt[3] = '{1'b1, 16'h0055, 8'h77, 3,  8'h3C};
        xt[4] = '{1'b0, 16'h0055, 8'h00, 3,  8'h77};
        xt[5] = '{1'b0, 16'h1234, 8'h00, 10, 8'hA5};
        xt[6] = '{1'b1, 16'h0066, 8'h11, 0,  8'hA5};
        mt[0] = '{16'h0041, 1'b0, 1'b1, 8'h99, 1'b0, 8'h00};
        mt[1] = '{16'h0041, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99};
        mt[2] = '{16'h0055, 1'b1, 1'b0, 8'hC3, 1'b1, 8'h77};
        mt[3] = '{16'h0066, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11};
        mt[4] = '{16'hBEEF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
        mt[5] = '{16'h1234, 1'b1, 1'b1, 8'h0F, 1'b1, 8'hA5};

        reset = 1'b1;
        cpu_idle();
        cpu_mem_address = 16'h00AA;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 16'h0; ext_wdata = 8'h0;
        #1;
        chk("rst_outs", {ext_busy, ext_ack, ext_timeout, grant_ext}, 4'b0000);
        chk("rst_rdata", ext_rdata, 0);
        chk("rst_pass_addr", ram_address, 16'h00AA);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) xfer(xt[i]);

        @(negedge clk);
        cpu_idle();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0040;
        g = 0; k = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            #1;
            g += int'(grant_ext);
            k += int'(ext_ack);
        end
        ext_req = 1'b0;
        chk("held_req_grants", g, 3);
        chk("held_req_acks", k, 3);
        chk("held_req_rdata", ext_rdata, 8'h3C);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_mem_address = mt[i].a;
            cpu_mem_read = mt[i].rd;
            cpu_mem_write = mt[i].wr;
            cpu_mem_data_out = mt[i].d;
            #1;
            chk("mux_addr", ram_address, mt[i].a);
            chk("mux_rw", {ram_read, ram_write}, {mt[i].rd, mt[i].wr});
            chk("mux_wdata", ram_wdata, mt[i].d);
            chk("mux_grant", grant_ext, 0);
            if (mt[i].chk_din) chk("mux_din", cpu_mem_data_in, mt[i].din);
        end

        @(negedge clk);
        cpu_idle();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0077; ext_wdata = 8'hEE;
        @(negedge clk);
        ext_req = 1'b0;
        cpu_mem_read = 1'b1; cpu_mem_write = 1'b1; cpu_mem_address = 16'h0300;
        #1;
        chk("illegal_grant", grant_ext, 0);
        chk("illegal_rw", {ram_read, ram_write}, 2'b11);
        chk("illegal_addr", ram_address, 16'h0300);
        chk("illegal_busy", ext_busy, 1);
        @(negedge clk);
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {ext_busy, ext_ack, ext_timeout, grant_ext}, 4'b0000);
        chk("mid_rst_rdata", ext_rdata, 0);
        chk("mid_rst_pass", {ram_address, ram_write}, {16'h0300, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        g = 0; k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            g += int'(grant_ext);
            k += int'(ext_ack);
        end
        chk("post_rst_grants", g, 0);
        chk("post_rst_acks", k, 0);
        chk("post_rst_busy", ext_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
